// File: rtl/emission_weight_pkg.sv
// Shared definitions for the emission-weighting stage of the HMM forward pass:
// default sizes, the Q0.DATA_PREC multiply and the control FSM states.
package emission_weight_pkg;

    localparam int unsigned DATA_PREC     = 16;
    localparam int unsigned HIDDEN_STATES = 4;
    localparam int unsigned OBS_SYMBOLS   = 4;
    localparam int unsigned OBS_W         = $clog2(OBS_SYMBOLS + 1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    // Q0.DATA_PREC product, truncated back to DATA_PREC fractional bits.
    function automatic logic [DATA_PREC-1:0] multiply(input logic [DATA_PREC-1:0] a,
                                                      input logic [DATA_PREC-1:0] b);
        logic [2*DATA_PREC-1:0] ext_a;
        logic [2*DATA_PREC-1:0] ext_b;
        ext_a = {{DATA_PREC{1'b0}}, a};
        ext_b = {{DATA_PREC{1'b0}}, b};
        return DATA_PREC'((ext_a * ext_b) >> DATA_PREC);
    endfunction

endpackage

// File: rtl/sat_accum.sv
// Saturating unsigned accumulator: synchronous clear, add-enable, clamps at the
// all-ones value instead of wrapping.
module sat_accum #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             add_en,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH:0]   wide;

    always_comb begin
        wide  = {1'b0, sum_q} + {1'b0, operand};
        sum_d = sum_q;
        if (clr) begin
            sum_d = '0;
        end else if (add_en) begin
            sum_d = wide[WIDTH] ? {WIDTH{1'b1}} : wide[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/emission_weight.sv
// Emission weighting: alpha[k] = pred[k] * B[k][obs], one element per cycle through a
// single shared multiplier, with a saturating running sum of the weighted vector.
module emission_weight #(
    parameter int unsigned DATA_PREC     = emission_weight_pkg::DATA_PREC,
    parameter int unsigned HIDDEN_STATES = emission_weight_pkg::HIDDEN_STATES,
    parameter int unsigned OBS_SYMBOLS   = emission_weight_pkg::OBS_SYMBOLS,
    parameter int unsigned OBS_W         = $clog2(OBS_SYMBOLS + 1)
) (
    input  logic                                                    clk,
    input  logic                                                    rst_n,
    input  logic                                                    in_valid,
    output logic                                                    in_ready,
    input  logic [HIDDEN_STATES-1:0][DATA_PREC-1:0]                 pred,
    input  logic [OBS_W-1:0]                                        obs,
    input  logic [OBS_SYMBOLS-1:0][HIDDEN_STATES-1:0][DATA_PREC-1:0] emis,
    output logic                                                    out_valid,
    input  logic                                                    out_ready,
    output logic [HIDDEN_STATES-1:0][DATA_PREC-1:0]                 alpha,
    output logic [DATA_PREC-1:0]                                    alpha_sum,
    output logic                                                    obs_err
);

    import emission_weight_pkg::*;

    localparam int unsigned KW    = (HIDDEN_STATES > 1) ? $clog2(HIDDEN_STATES) : 1;
    localparam logic [KW-1:0] KLast = KW'(HIDDEN_STATES - 1);

    state_e                                  state_q, state_d;
    logic [KW-1:0]                           k_q, k_d;
    logic [HIDDEN_STATES-1:0][DATA_PREC-1:0] pred_q;
    logic [HIDDEN_STATES-1:0][DATA_PREC-1:0] alpha_q;
    logic [OBS_W-1:0]                        obs_q;
    logic                                    obs_err_q;
    logic                                    obs_bad;
    logic                                    accept;
    logic                                    calc_en;
    logic [DATA_PREC-1:0]                    pred_k;
    logic [DATA_PREC-1:0]                    emis_k;
    logic [DATA_PREC-1:0]                    prod;

    assign obs_bad = (32'(obs) >= OBS_SYMBOLS);

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        calc_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    k_d     = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                calc_en = 1'b1;
                if (k_q == KLast) begin
                    k_d     = '0;
                    state_d = StDone;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // An out-of-range symbol selects no row, so every product collapses to zero.
    always_comb begin
        emis_k = '0;
        for (int o = 0; o < OBS_SYMBOLS; o++) begin
            if (obs_q == OBS_W'(o)) begin
                emis_k = emis[o][k_q];
            end
        end
    end

    assign pred_k = pred_q[k_q];
    assign prod   = multiply(pred_k, emis_k);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            k_q       <= '0;
            pred_q    <= '0;
            obs_q     <= '0;
            obs_err_q <= 1'b0;
            alpha_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            if (accept) begin
                pred_q    <= pred;
                obs_q     <= obs;
                obs_err_q <= obs_bad;
            end
            if (calc_en) begin
                alpha_q[k_q] <= prod;
            end
        end
    end

    sat_accum #(
        .WIDTH (DATA_PREC)
    ) u_sat_accum (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (accept),
        .add_en  (calc_en),
        .operand (prod),
        .sum     (alpha_sum)
    );

    assign alpha   = alpha_q;
    assign obs_err = obs_err_q;

endmodule

// File: tb/tb_emission_weight.sv
// Directed and randomized checks of emission_weight against an arithmetic reference
// model: values, latency, backpressure, saturation, bad symbols, reset and throughput.
module tb_emission_weight;

    localparam int N  = 4;
    localparam int P  = 16;
    localparam int M  = 4;
    localparam int OW = 3;

    logic                       clk;
    logic                       rst_n;
    logic                       in_valid;
    logic                       in_ready;
    logic [N-1:0][P-1:0]        pred;
    logic [OW-1:0]              obs;
    logic [M-1:0][N-1:0][P-1:0] emis;
    logic                       out_valid;
    logic                       out_ready;
    logic [N-1:0][P-1:0]        alpha;
    logic [P-1:0]               alpha_sum;
    logic                       obs_err;

    int checks   = 0;
    int failures = 0;

    emission_weight #(
        .DATA_PREC     (P),
        .HIDDEN_STATES (N),
        .OBS_SYMBOLS   (M),
        .OBS_W         (OW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pred      (pred),
        .obs       (obs),
        .emis      (emis),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alpha     (alpha),
        .alpha_sum (alpha_sum),
        .obs_err   (obs_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Reference: alpha[k] = floor(pred[k]*B[k][o] / 2^P), sum clamped to 2^P-1.
    function automatic void model(input logic [N-1:0][P-1:0] p, input logic [OW-1:0] o,
                                  input logic [M-1:0][N-1:0][P-1:0] e,
                                  output logic [N-1:0][P-1:0] a, output logic [P-1:0] s,
                                  output logic err);
        longint total;
        longint prod;
        longint maxv;
        maxv  = (longint'(1) << P) - 1;
        total = 0;
        err   = (int'(o) >= M);
        for (int k = 0; k < N; k++) begin
            prod = 0;
            if (!err) prod = (longint'(p[k]) * longint'(e[o][k])) / (longint'(1) << P);
            a[k]  = prod[P-1:0];
            total = total + prod;
        end
        if (total > maxv) total = maxv;
        s = total[P-1:0];
    endfunction

    task automatic check_result(input string tag);
        logic [N-1:0][P-1:0] ea;
        logic [P-1:0]        es;
        logic                ee;
        model(pred, obs, emis, ea, es, ee);
        check({tag, ".alpha"}, 64'(alpha), 64'(ea));
        check({tag, ".sum"}, 64'(alpha_sum), 64'(es));
        check({tag, ".err"}, 64'(obs_err), 64'(ee));
    endtask

    // One full transaction; hold = cycles out_ready stays low once out_valid is up.
    task automatic send_and_check(input string tag, input int hold, input bit check_lat);
        int cyc;
        int lat;
        logic [N-1:0][P-1:0] snap;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, ".idle_ready"}, 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            check({tag, ".busy_ready"}, 64'(in_ready), 64'(0));
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".out_valid"}, 64'(out_valid), 64'(1));
        if (check_lat) check({tag, ".latency"}, 64'(lat), 64'(N + 1));
        check_result(tag);
        snap = alpha;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, ".hold_valid"}, 64'(out_valid), 64'(1));
            check({tag, ".hold_ready"}, 64'(in_ready), 64'(0));
            check({tag, ".hold_alpha"}, 64'(alpha), 64'(snap));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".post_valid"}, 64'(out_valid), 64'(0));
        check({tag, ".post_ready"}, 64'(in_ready), 64'(1));
    endtask

    task automatic randomize_inputs(input int max_obs);
        for (int k = 0; k < N; k++) pred[k] = P'($urandom);
        for (int o = 0; o < M; o++)
            for (int k = 0; k < N; k++) emis[o][k] = P'($urandom);
        obs = OW'($urandom_range(max_obs, 0));
    endtask

    initial begin
        logic [N-1:0][P-1:0] pred_b;
        logic [OW-1:0]       obs_b;
        logic [N-1:0][P-1:0] pred_a;
        logic [OW-1:0]       obs_a;
        int  cnt;
        bit  seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pred      = '0;
        obs       = '0;
        emis      = '0;

        // Reset state
        #2;
        check("rst.alpha", 64'(alpha), 64'(0));
        check("rst.sum", 64'(alpha_sum), 64'(0));
        check("rst.err", 64'(obs_err), 64'(0));
        check("rst.out_valid", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst.in_ready", 64'(in_ready), 64'(1));

        // Basic vector with latency check
        pred       = {N{16'h8000}};
        obs        = 3'd1;
        emis[1][0] = 16'h8000;
        emis[1][1] = 16'h4000;
        emis[1][2] = 16'hFFFF;
        emis[1][3] = 16'h0000;
        emis[0]    = {N{16'h1234}};
        send_and_check("basic", 0, 1'b1);
        check("basic.alpha_const", 64'(alpha), 64'h0000_7FFF_2000_4000);
        check("basic.sum_const", 64'(alpha_sum), 64'hDFFF);

        // Backpressure: output held for 5 cycles
        send_and_check("bp", 5, 1'b1);

        // Saturation
        pred = {N{16'hFFFF}};
        emis = {(M * N){16'hFFFF}};
        obs  = 3'd2;
        send_and_check("sat", 1, 1'b0);
        check("sat.alpha_const", 64'(alpha), 64'hFFFE_FFFE_FFFE_FFFE);
        check("sat.sum_const", 64'(alpha_sum), 64'hFFFF);

        // Out-of-range observation
        randomize_inputs(3);
        obs = 3'd4;
        send_and_check("badobs", 0, 1'b0);
        check("badobs.err_const", 64'(obs_err), 64'(1));

        // Reset in the middle of CALC (k=2)
        randomize_inputs(3);
        pred = {N{16'h9000}};
        emis = {(M * N){16'hC000}};
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst.alpha", 64'(alpha), 64'(0));
        check("midrst.sum", 64'(alpha_sum), 64'(0));
        check("midrst.err", 64'(obs_err), 64'(0));
        check("midrst.out_valid", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("midrst.no_pulse", 64'(seen), 64'(0));
        randomize_inputs(3);
        send_and_check("midrst.after", 0, 1'b1);

        // Back-to-back with in_valid held and out_ready high
        randomize_inputs(3);
        pred_a = pred;
        obs_a  = obs;
        for (int k = 0; k < N; k++) pred_b[k] = P'($urandom);
        obs_b = OW'((int'(obs_a) + 1) % M);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        pred = pred_b;
        obs  = obs_b;
        cnt  = 0;
        seen = 1'b0;
        while (cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
            if (out_valid) begin
                pred = pred_a;
                obs  = obs_a;
                check_result("b2b.first");
                pred = pred_b;
                obs  = obs_b;
                seen = 1'b1;
            end
            if (in_ready) break;
        end
        check("b2b.first_seen", 64'(seen), 64'(1));
        check("b2b.spacing", 64'(cnt + 1), 64'(N + 2));
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("b2b.second_valid", 64'(out_valid), 64'(1));
        check_result("b2b.second");
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("b2b.idle", 64'(in_ready), 64'(1));

        // Randomized beats, including out-of-range symbols
        for (int t = 0; t < 12; t++) begin
            randomize_inputs(5);
            send_and_check("rand", int'($urandom_range(3, 0)), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/emission_weight.md
EMISSION_WEIGHT -- requirements
Module: emission_weight

Interface
REQ-001 Parameter DATA_PREC, default 16, SHALL be the fixed-point word width: unsigned Q0.DATA_PREC probability.
REQ-002 Parameter HIDDEN_STATES, default 4, SHALL be the number of hidden states N.
REQ-003 Parameter OBS_SYMBOLS, default 4, SHALL be the observation alphabet size M.
REQ-004 Parameter OBS_W, default $clog2(OBS_SYMBOLS+1), SHALL be the width of the observation index.
REQ-005 Port list, clock and reset first:
- clk, input, 1: sole clock; all state updates on rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: pred and obs are valid.
- in_ready, output, 1: block accepts a beat.
- pred, input, DATA_PREC x HIDDEN_STATES: predicted vector, i.e. the transition-matrix product.
- obs, input, OBS_W: observation symbol index.
- emis, input, DATA_PREC x OBS_SYMBOLS x HIDDEN_STATES: emission table, quasi-static; row emis[o] is column B[:,o].
- out_valid, output, 1: alpha and alpha_sum are valid.
- out_ready, input, 1: consumer accepts.
- alpha, output, DATA_PREC x HIDDEN_STATES: emission-weighted vector.
- alpha_sum, output, DATA_PREC: saturating sum of alpha.
- obs_err, output, 1: obs was out of range for this beat.

Function
REQ-006 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE, encoded as a typedef enum.
REQ-007 IDLE: in_ready=1. On in_valid&in_ready, SHALL capture pred and obs into registers, clear the accumulator, set k=0, and enter CALC.
REQ-008 CALC: each cycle SHALL compute alpha[k]=multiply(pred_q[k], emis[obs_q][k]) and add it to the accumulator, using exactly one multiplier shared across states.
REQ-009 CALC: when k=N-1, SHALL move to DONE; otherwise k increments.
REQ-010 multiply(a,b) SHALL be (a*b)>>DATA_PREC, truncated, DATA_PREC bits.
REQ-011 The accumulator SHALL saturate at 2^DATA_PREC-1 and never wrap.
REQ-012 If obs_q >= OBS_SYMBOLS, every alpha[k] SHALL be 0, alpha_sum SHALL be 0, and obs_err SHALL be 1 for that beat; otherwise obs_err SHALL be 0.
REQ-013 DONE: out_valid=1. alpha, alpha_sum and obs_err SHALL be registered and held stable until out_valid&out_ready. On that handshake the FSM SHALL return to IDLE.
REQ-014 in_ready SHALL be 0 in CALC and DONE; no input is buffered.
REQ-015 Latency: with acceptance at edge e0, out_valid SHALL rise after edge e0+N. Minimum beat spacing SHALL be N+2 cycles.
REQ-016 emis changes during CALC SHALL be outside spec; the block is not required to snapshot emis.

Reset
REQ-017 rst_n low SHALL asynchronously force IDLE, k=0, accumulator=0, alpha=0, alpha_sum=0, obs_err=0, out_valid=0. in_ready SHALL be 1 once reset is released.
REQ-018 Reset during CALC or DONE SHALL discard the in-flight beat without emitting an output.

Structure
REQ-019 DATA_PREC, HIDDEN_STATES, OBS_SYMBOLS, OBS_W, the multiply function and the FSM state typedef SHALL live in the shared defs package.
REQ-020 Saturating accumulation SHALL be a single sub-module sat_accum (clear, add enable, DATA_PREC operand and result); no other sub-modules.

Verification (N=4, DATA_PREC=16, M=4)
REQ-021 Basic: pred all 0x8000, obs=1, emis[1]={0x8000,0x4000,0xFFFF,0x0000}. Required: alpha={0x4000,0x2000,0x7FFF,0x0000}, alpha_sum=0xDFFF, obs_err=0.
REQ-022 Latency and backpressure: hold out_ready=0 for 5 cycles after out_valid. Required: out_valid rises exactly 5 cycles (N+1) after acceptance; alpha stays stable; in_ready=0 throughout; one handshake then returns to IDLE.
REQ-023 Saturation: pred all 0xFFFF, emis all 0xFFFF. Required: each alpha[k]=0xFFFE, alpha_sum=0xFFFF.
REQ-024 Bad observation: obs=4. Required: alpha all 0, alpha_sum=0, obs_err=1.
REQ-025 Reset mid-CALC: assert rst_n=0 at k=2. Required: all outputs 0 immediately, no out_valid pulse; a following beat produces correct results.
REQ-026 Back-to-back: in_valid held high with out_ready=1 and two different beats. Required: both results are correct and in order, and the second acceptance occurs N+2 cycles after the first.
